// File: rtl/cond_unit.sv
// cond_unit: stores compare flags and resolves branch conditions against them to drive PC_SRC
module cond_unit (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] COND,
    input  logic       BRANCH,
    input  logic       NO_REG_WR,
    input  logic [1:0] FLAGS,
    output logic       PC_SRC
);
    logic [1:0] flg;
    logic       cond_true;
    always_ff @(posedge CLK or posedge RST)
        if (RST)
            flg <= 2'b00;
        else if (NO_REG_WR)
            flg <= FLAGS;
    // Only the stored flags are used, so a same-cycle compare never bypasses into a branch
    always_comb begin
        cond_true = (COND == 2'b11) ? 1'b1 :
                    (COND == 2'b10) ? flg[1] :
                    (COND == 2'b01) ? flg[0] :
                                      (flg == 2'b00);
        PC_SRC    = BRANCH & cond_true;
    end
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed plan plus randomized traffic checked against a flag-semantics model
module tb_cond_unit;
    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] COND;
    logic       BRANCH;
    logic       NO_REG_WR;
    logic [1:0] FLAGS;
    logic       PC_SRC;
    logic [1:0] mflg;
    int         pass_cnt = 0;
    int         total = 0;

    cond_unit dut (
        .CLK(CLK), .RST(RST), .COND(COND), .BRANCH(BRANCH),
        .NO_REG_WR(NO_REG_WR), .FLAGS(FLAGS), .PC_SRC(PC_SRC)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        if (obs === exp)
            pass_cnt++;
        else
            $display("FAIL %s: PC_SRC=%b expected %b", tag, obs, exp);
    endtask

    function automatic logic model_pc(input logic br, input logic [1:0] c, input logic [1:0] f);
        logic eq, lt, t;
        eq = f[1];
        lt = f[0];
        case (c)
            2'b10:   t = eq;
            2'b01:   t = lt;
            2'b00:   t = !eq && !lt;
            default: t = 1'b1;
        endcase
        return br && t;
    endfunction

    task automatic tick();
        @(posedge CLK);
        if (RST)
            mflg = 2'b00;
        else if (NO_REG_WR === 1'b1)
            mflg = FLAGS;
        #1;
    endtask

    task automatic load(input logic [1:0] f);
        BRANCH = 1'b0;
        NO_REG_WR = 1'b1;
        FLAGS = f;
        tick();
        NO_REG_WR = 1'b0;
    endtask

    task automatic hold(input logic [1:0] f);
        NO_REG_WR = 1'b0;
        FLAGS = f;
        tick();
    endtask

    task automatic probe(input string tag, input logic br, input logic [1:0] c, input logic exp);
        BRANCH = br;
        COND = c;
        #1;
        check(tag, PC_SRC, exp);
    endtask

    initial begin
        RST = 1'b1;
        COND = 2'b00;
        BRANCH = 1'b0;
        NO_REG_WR = 1'b0;
        FLAGS = 2'b00;
        mflg = 2'b00;
        #12;
        probe("rst_bgt", 1'b1, 2'b00, 1'b1);
        probe("rst_beq", 1'b1, 2'b10, 1'b0);
        RST = 1'b0;
        tick();
        for (int i = 0; i < 4; i++)
            probe("nobranch", 1'b0, 2'(i), 1'b0);
        load(2'b10); hold(2'b00);
        probe("beq_taken", 1'b1, 2'b10, 1'b1);
        load(2'b01); hold(2'b00);
        probe("beq_not", 1'b1, 2'b10, 1'b0);
        probe("blt_taken", 1'b1, 2'b01, 1'b1);
        probe("blt_as_beq", 1'b1, 2'b10, 1'b0);
        probe("bgt_on_lt", 1'b1, 2'b00, 1'b0);
        load(2'b00);
        probe("bgt_taken", 1'b1, 2'b00, 1'b1);
        load(2'b10);
        probe("bgt_on_eq", 1'b1, 2'b00, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            load(2'(i));
            probe("b_always", 1'b1, 2'b11, 1'b1);
        end
        load(2'b10);
        NO_REG_WR = 1'b0;
        FLAGS = 2'bxx;
        tick();
        probe("x_flags_hold", 1'b1, 2'b10, 1'b1);
        load(2'b00);
        NO_REG_WR = 1'b1;
        FLAGS = 2'b10;
        probe("same_pre", 1'b1, 2'b10, 1'b0);
        tick();
        check("same_post", PC_SRC, 1'b1);
        load(2'b10);
        probe("pre_reset", 1'b1, 2'b10, 1'b1);
        RST = 1'b1;
        mflg = 2'b00;
        probe("async_beq", 1'b1, 2'b10, 1'b0);
        probe("async_bgt", 1'b1, 2'b00, 1'b1);
        NO_REG_WR = 1'b1;
        FLAGS = 2'b10;
        tick();
        RST = 1'b0;
        NO_REG_WR = 1'b0;
        probe("rst_priority", 1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 400; i++) begin
            RST = ($urandom_range(0, 19) == 0);
            if (RST)
                mflg = 2'b00;
            NO_REG_WR = $urandom_range(0, 1);
            FLAGS = 2'($urandom);
            BRANCH = $urandom_range(0, 1);
            COND = 2'($urandom);
            #1;
            check("random", PC_SRC, model_pc(BRANCH, COND, mflg));
            tick();
        end
        RST = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
